// File: rtl/prog_mem_fetch_ctrl.sv
// prog_mem_fetch_ctrl: instruction-fetch sequencer for a combinational-read
// program memory. Issues word addresses from fetch_pc, buffers returned words
// in a 2-entry prefetch queue and presents the head to decode over
// valid/ready. Redirects flush the queue and restart fetch at redirect_pc.
//
// Optional feature (macro PROG_MEM_DEBUG_PORT_EN): a debug requester shares
// the single memory read port with fetch using alternating arbitration.
// Without the macro the dbg_* ports exist but are inert.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   fetch_en                         allow new fetches
//   redirect_valid, redirect_pc      flush + restart fetch address
//   mem_pc / mem_instr               memory address out, word back (comb)
//   instr_valid/instr_ready          head handshake to decode
//   instr, instr_pc                  head word and its word address
//   dbg_req, dbg_addr                debug read request (held until grant)
//   dbg_gnt                          debug owns memory port (comb)
//   dbg_rvalid, dbg_rdata            registered debug read result
module prog_mem_fetch_ctrl #(
  parameter int unsigned INSTR_ADDR_WIDTH = 20,
  parameter int unsigned STEP             = 4,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [INSTR_ADDR_WIDTH-1:0]   redirect_pc,
  output logic [INSTR_ADDR_WIDTH-1:0]   mem_pc,
  input  logic [STEP*8-1:0]             mem_instr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [STEP*8-1:0]             instr,
  output logic [INSTR_ADDR_WIDTH-1:0]   instr_pc,
  input  logic                          dbg_req,
  input  logic [INSTR_ADDR_WIDTH-1:0]   dbg_addr,
  output logic                          dbg_gnt,
  output logic                          dbg_rvalid,
  output logic [STEP*8-1:0]             dbg_rdata
);

  localparam int unsigned AW = INSTR_ADDR_WIDTH;
  localparam int unsigned DW = STEP * 8;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_DEBUG = 1'b1} owner_e;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]    count_q, count_d;
  logic [AW-1:0] pc_q   [2];
  logic [AW-1:0] pc_d   [2];
  logic [DW-1:0] word_q [2];
  logic [DW-1:0] word_d [2];
  owner_e        last_owner_q, last_owner_d;

  logic       pop;
  logic [1:0] count_after_pop;
  logic       fetch_want;
  logic       dbg_want;
  logic       fetch_go;
  logic       dbg_go;
  logic       slot;

  // Head of the queue is always entry 0
  assign instr_valid = (count_q != 2'd0);
  assign instr       = word_q[0];
  assign instr_pc    = pc_q[0];

  assign pop             = instr_valid && instr_ready;
  assign count_after_pop = count_q - {1'b0, pop};
  assign fetch_want      = fetch_en && !redirect_valid && (count_after_pop < 2'd2);

`ifdef PROG_MEM_DEBUG_PORT_EN
  logic          dbg_rvalid_q;
  logic [DW-1:0] dbg_rdata_q;

  assign dbg_want   = dbg_req;
  // Grant is masked while in reset so the port looks idle to the memory
  assign dbg_gnt    = reset_n && dbg_go;
  assign mem_pc     = dbg_gnt ? dbg_addr : fetch_pc_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

  // Debug read result: one-cycle valid pulse, data held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      dbg_rvalid_q <= dbg_go;
      if (dbg_go) dbg_rdata_q <= mem_instr;
    end
  end
`else
  logic unused_dbg;

  assign dbg_want   = 1'b0;
  assign dbg_gnt    = 1'b0;
  assign mem_pc     = fetch_pc_q;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = '0;
  assign unused_dbg = ^{dbg_req, dbg_addr};
`endif

  // Port arbitration: on contention the side not served last time wins
  assign fetch_go = fetch_want && (!dbg_want || last_owner_q == OWN_DEBUG);
  assign dbg_go   = dbg_want && (!fetch_want || last_owner_q == OWN_FETCH);

  // Fetch position within the queue after this cycle's pop
  assign slot = count_after_pop[0];

  // Next-state: queue shift/push, fetch pointer, arbitration history
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    pc_d         = pc_q;
    word_d       = word_q;
    last_owner_d = last_owner_q;

    if (fetch_go)    last_owner_d = OWN_FETCH;
    else if (dbg_go) last_owner_d = OWN_DEBUG;

    if (redirect_valid) begin
      count_d    = 2'd0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (pop) begin
        pc_d[0]   = pc_q[1];
        word_d[0] = word_q[1];
      end
      if (fetch_go) begin
        pc_d[slot]   = fetch_pc_q;
        word_d[slot] = mem_instr;
        fetch_pc_d   = fetch_pc_q + AW'(1);
      end
      count_d = count_after_pop + {1'b0, fetch_go};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      count_q      <= 2'd0;
      pc_q[0]      <= '0;
      pc_q[1]      <= '0;
      word_q[0]    <= '0;
      word_q[1]    <= '0;
      last_owner_q <= OWN_DEBUG;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      word_q       <= word_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_prog_mem_fetch_ctrl.sv
// Bench for prog_mem_fetch_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_prog_mem_fetch_ctrl;

  localparam int unsigned AW  = 20;
  localparam int unsigned AW5 = 5;
`ifdef PROG_MEM_DEBUG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic           fetch_en, redirect_valid, instr_ready, dbg_req;
  logic [AW-1:0]  redirect_pc, dbg_addr, mem_pc, instr_pc;
  logic [31:0]    mem_instr, instr, dbg_rdata;
  logic           instr_valid, dbg_gnt, dbg_rvalid;

  logic [AW5-1:0] mem_pc5, instr_pc5, dbg_addr5_unused_out;
  logic [31:0]    mem_instr5, instr5, dbg_rdata5;
  logic           instr_valid5, dbg_gnt5, dbg_rvalid5;

  always #5 clk = ~clk;

  // Program memory contents: fixed hash of the word address
  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    logic [63:0] p;
    p = 64'(a) * 64'h9E37_79B1;
    return p[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_instr  = memf(mem_pc);
  assign mem_instr5 = memf(AW'(mem_pc5));
  assign dbg_addr5_unused_out = '0;

  prog_mem_fetch_ctrl #(.INSTR_ADDR_WIDTH(AW), .STEP(4), .RESET_PC(20'h10)) u_dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_pc(mem_pc), .mem_instr(mem_instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
  );

  // Narrow-address instance for the wrap-around case
  prog_mem_fetch_ctrl #(.INSTR_ADDR_WIDTH(AW5), .STEP(4), .RESET_PC(5'h1E)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .fetch_en(1'b1),
    .redirect_valid(1'b0), .redirect_pc(5'h0),
    .mem_pc(mem_pc5), .mem_instr(mem_instr5),
    .instr_valid(instr_valid5), .instr_ready(1'b1),
    .instr(instr5), .instr_pc(instr_pc5),
    .dbg_req(1'b0), .dbg_addr(dbg_addr5_unused_out), .dbg_gnt(dbg_gnt5),
    .dbg_rvalid(dbg_rvalid5), .dbg_rdata(dbg_rdata5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched entries, fetch pointer, who was served last
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   w;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_fpc;
  bit            m_last_dbg;
  bit            m_rvalid;
  logic [31:0]   m_rdata;

  // Debug requester state
  bit            dbg_pend;
  int            dbg_rate;
  bit            dbg_fix;

  // Values sampled in the latest cycle, for directed literal checks
  logic          a_valid, a_gnt, a_rvalid, a5_valid;
  logic [AW-1:0] a_pc, a_mem_pc;
  logic [31:0]   a_instr, a_rdata;
  logic [AW5-1:0] a5_pc;

  task automatic model_reset();
    mq.delete();
    m_fpc      = 20'h10;
    m_last_dbg = 1'b1;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
  endtask

  // One clock cycle: drive inputs, compare everything, advance the model
  task automatic step(input logic fe, input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    bit   pop, want, dreq, to_fetch, to_dbg;
    int   sz;
    ent_t e;
    @(negedge clk);
    reset_n        = 1'b1;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    if (!dbg_pend && ($urandom_range(99) < 32'(dbg_rate))) begin
      dbg_pend = 1'b1;
      dbg_addr = dbg_fix ? 20'h3 : AW'($urandom);
    end
    dbg_req = dbg_pend;
    #1;
    a_valid = instr_valid; a_pc = instr_pc; a_instr = instr; a_mem_pc = mem_pc;
    a_gnt = dbg_gnt; a_rvalid = dbg_rvalid; a_rdata = dbg_rdata;
    a5_valid = instr_valid5; a5_pc = instr_pc5;

    sz = mq.size();
    chk("instr_valid", 32'(instr_valid), 32'(sz > 0));
    if (sz > 0) begin
      chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
      chk("instr", instr, mq[0].w);
    end

    pop  = (sz > 0) && rdy;
    want = fe && !rv && ((sz - int'(pop)) < 2);
    dreq = DBG_EN && dbg_req;
    to_fetch = 1'b0;
    to_dbg   = 1'b0;
    if (want && dreq) begin
      if (m_last_dbg) to_fetch = 1'b1;
      else            to_dbg   = 1'b1;
    end else if (want) to_fetch = 1'b1;
    else if (dreq)     to_dbg   = 1'b1;

    chk("mem_pc", 32'(mem_pc), to_dbg ? 32'(dbg_addr) : 32'(m_fpc));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(to_dbg));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("dbg_rdata", dbg_rdata, m_rdata);
`ifndef PROG_MEM_DEBUG_PORT_EN
    chk("dbg_rdata_off", dbg_rdata, 32'h0);
`endif

    if (dbg_gnt) dbg_pend = 1'b0;

    if (pop) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_fpc = rpc;
    end else if (to_fetch) begin
      e.pc = m_fpc;
      e.w  = memf(m_fpc);
      mq.push_back(e);
      m_fpc = m_fpc + 20'd1;
    end
    m_rvalid = to_dbg;
    if (to_dbg) m_rdata = memf(dbg_addr);
    if (to_fetch)    m_last_dbg = 1'b0;
    else if (to_dbg) m_last_dbg = 1'b1;
  endtask

  logic          g_prev;
  logic [AW-1:0] pc_prev;

  initial begin
    reset_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; dbg_req = DBG_EN; dbg_addr = 20'h3;
    dbg_pend = 1'b0; dbg_rate = 0; dbg_fix = 1'b0;
    model_reset();

    // Reset state, with a debug request pending to show the grant is masked
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    chk("rst_mem_pc", 32'(mem_pc), 32'h10);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_mem_pc5", 32'(mem_pc5), 32'h1E);
    dbg_req = 1'b0;

    // Streaming after reset release, plus 5-bit wrap on the narrow instance
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (i == 1) begin
        chk("first_valid", 32'(a_valid), 32'h0);
        chk("first_mem_pc", 32'(a_mem_pc), 32'h10);
      end else begin
        chk("stream_pc", 32'(a_pc), 32'h10 + 32'(i - 2));
        chk("stream_instr", a_instr, memf(AW'(32'h10 + 32'(i - 2))));
        chk("wrap_valid5", 32'(a5_valid), 32'h1);
      end
      if (i == 2) chk("wrap_pc5_a", 32'(a5_pc), 32'h1E);
      if (i == 3) chk("wrap_pc5_b", 32'(a5_pc), 32'h1F);
      if (i == 4) chk("wrap_pc5_c", 32'(a5_pc), 32'h00);
      if (i == 5) chk("wrap_pc5_d", 32'(a5_pc), 32'h01);
    end

    // Back-pressure: head holds, then drains with no gap or duplicate
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      chk("stall_valid", 32'(a_valid), 32'h1);
      chk("stall_pc", 32'(a_pc), 32'h14);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      chk("drain_pc", 32'(a_pc), 32'h14 + 32'(i));
    end

    // Redirect with a full queue
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 20'h40, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("redir_flushed", 32'(a_valid), 32'h0);
    chk("redir_mem_pc", 32'(a_mem_pc), 32'h40);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("redir_valid", 32'(a_valid), 32'h1);
    chk("redir_pc", 32'(a_pc), 32'h40);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("redir_next_pc", 32'(a_pc), 32'h41);

    // Continuous debug request against continuous fetch
    dbg_rate = 100; dbg_fix = 1'b1;
    step(1'b1, 1'b0, '0, 1'b1);
    g_prev = a_gnt; pc_prev = a_pc;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
`ifdef PROG_MEM_DEBUG_PORT_EN
      chk("dbg_alternate", 32'(a_gnt), 32'(!g_prev));
      if (g_prev) begin
        chk("dbg_pulse", 32'(a_rvalid), 32'h1);
        chk("dbg_data_03", a_rdata, memf(20'h3));
      end
`else
      chk("nodbg_gnt", 32'(a_gnt), 32'h0);
      chk("nodbg_rvalid", 32'(a_rvalid), 32'h0);
      chk("nodbg_rate", 32'(a_valid), 32'h1);
      chk("nodbg_seq", 32'(a_pc), 32'(pc_prev + 20'd1));
`endif
      g_prev = a_gnt; pc_prev = a_pc;
    end
    dbg_fix = 1'b0;

    // Randomized traffic
    dbg_rate = 30;
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] rpc;
      rpc = ($urandom_range(3) == 0) ? 20'hFFFFE : AW'($urandom);
      step(1'($urandom_range(9) != 0), 1'($urandom_range(29) == 0), rpc,
           1'($urandom_range(3) != 0));
    end

    // Asynchronous reset in the middle of a cycle drops everything at once
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_pc", 32'(instr_pc), 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_rvalid", 32'(dbg_rvalid), 32'h0);
    chk("midrst_mem_pc", 32'(mem_pc), 32'h10);
    chk("midrst_gnt", 32'(dbg_gnt), 32'h0);
    model_reset();
    dbg_pend = 1'b0;
    dbg_req  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(7) != 0), 1'($urandom_range(39) == 0), AW'($urandom),
           1'($urandom_range(2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/prog_mem_fetch_ctrl.md
# prog_mem_fetch_ctrl

Instruction-fetch controller that sequences the program-memory word address, buffers fetched words in a 2-entry prefetch queue, and hands them to the decode stage over a valid/ready handshake. It sits between the core's PC/branch logic and the combinational-read program memory, and optionally shares the memory's single read port with a debug read requester.

## Interface
- INSTR_ADDR_WIDTH, 20, word-address width; memory holds 2**INSTR_ADDR_WIDTH words
- STEP, 4, bytes per instruction word; data width STEP*8
- RESET_PC, 0, word address of first fetch after reset
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_en  in  1  enables issuing new fetches (running core)
- redirect_valid  in  1  branch/jump/trap: flush queue and restart fetch
- redirect_pc  in  INSTR_ADDR_WIDTH  new word address
- mem_pc  out  INSTR_ADDR_WIDTH  address to program memory (combinational)
- mem_instr  in  STEP*8  word returned combinationally for mem_pc
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr  out  STEP*8  head instruction word
- instr_pc  out  INSTR_ADDR_WIDTH  word address of head
- dbg_req  in  1  debug read request (DEBUG_PORT_EN only)
- dbg_addr  in  INSTR_ADDR_WIDTH  debug read address
- dbg_gnt  out  1  debug owns memory port this cycle (combinational)
- dbg_rvalid  out  1  registered debug read data valid
- dbg_rdata  out  STEP*8  registered debug read data

## Operation
- State: fetch_pc register, 2-entry queue {pc, word} with count 0..2, last_owner bit (FETCH/DEBUG).
- Pop: instr_valid && instr_ready.
- fetch_want = fetch_en && !redirect_valid && (count - pop) < 2.
- Port arbitration per cycle: only fetch_want -> fetch; only dbg_req -> debug; both -> owner is opposite of last_owner (alternation, no starvation). last_owner updates only on a cycle where the port is used.
- Fetch cycle: mem_pc = fetch_pc; on edge push {fetch_pc, mem_instr}, fetch_pc <= fetch_pc + 1 modulo 2**INSTR_ADDR_WIDTH (wraps from all-ones to 0).
- Debug cycle: mem_pc = dbg_addr, dbg_gnt = 1; on edge dbg_rdata <= mem_instr, dbg_rvalid <= 1. dbg_rvalid is a one-cycle pulse; requester holds dbg_req until dbg_gnt.
- Idle port: mem_pc = fetch_pc, nothing captured.
- Redirect: highest priority. On edge count <= 0, fetch_pc <= redirect_pc, no push; pop in same cycle is still honoured by decode but the entry is discarded anyway. A debug grant in a redirect cycle proceeds normally.
- Simultaneous push and pop with count 2: allowed (count stays 2). Push with count 2 and no pop: never occurs (fetch_want low).
- fetch_en low: no new fetches; queue contents remain and drain via handshake.
- instr/instr_pc hold steady while instr_valid && !instr_ready.

## Timing
- Reset (async assert, sync-free deassert handled by caller): fetch_pc = RESET_PC, count = 0, last_owner = DEBUG, instr_valid = 0, instr = 0, instr_pc = 0 shown as head storage zeroed, dbg_rvalid = 0, dbg_rdata = 0. mem_pc = RESET_PC, dbg_gnt = 0 combinationally while in reset.
- Reset mid-operation: queue and pending debug result dropped immediately.
- Fetch latency: word requested in cycle N appears at head in N+1 if queue empty.
- Redirect latency: redirect in N -> fetch of redirect_pc in N+1 -> instr_valid with instr_pc = redirect_pc in N+2.
- Throughput: 1 instr/cycle with instr_ready held high and no debug traffic; 1 per 2 cycles under continuous debug contention.
- Debug latency: grant in N -> dbg_rvalid in N+1.

## Configuration
- PROG_MEM_DEBUG_PORT_EN defined: debug port and alternating arbitration present as above.
- Undefined: dbg_* ports still exist; dbg_req ignored, dbg_gnt = 0, dbg_rvalid = 0, dbg_rdata = 0; fetch owns the port every cycle.

## Test plan
- Reset with RESET_PC=0x10, fetch_en=1, instr_ready=1 -> instr_pc 0x10,0x11,0x12 on consecutive cycles starting 1 cycle after reset release, instr = memory contents.
- instr_ready=0 for 5 cycles -> count saturates at 2, mem fetch stops, head stays pc 0x10; ready=1 -> 0x10,0x11,0x12 with no gap or duplicate.
- Redirect to 0x40 while queue holds 2 -> both discarded, next valid instr_pc = 0x40 exactly 2 cycles later.
- INSTR_ADDR_WIDTH=5, start at 0x1E -> instr_pc sequence 0x1E,0x1F,0x00.
- With macro: dbg_req held with dbg_addr=0x03 and continuous fetch -> grants alternate, dbg_rdata = mem[0x03] one cycle after each grant, fetch stream ordered with no loss.
- Without macro: dbg_req=1 -> dbg_gnt and dbg_rvalid stay 0, fetch throughput 1/cycle.
